// File: rtl/noc_output_arbiter.sv
// Per-output-port round-robin packet arbiter for the NoC router.
// Define ARB_TIMEOUT_EN to add the stall watchdog that forces release of a stuck lock.
module noc_output_arbiter #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] req_i,
  input  logic [4:0] tail_i,
  input  logic       out_ready_i,
  output logic [4:0] grant_o,
  output logic [2:0] address_route_o,
  output logic       valid_o,
  output logic       xfer_o,
  output logic       timeout_o
);

  localparam logic ST_IDLE   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  logic       state;
  logic [2:0] owner;
  logic [2:0] rr_ptr;
  logic [2:0] winner;
  logic       found;
  logic [3:0] sum;
  logic [2:0] idx;
  logic [2:0] next_ptr;
  logic       locked;
  logic       release_tail;
  logic       expire;

  assign locked = (state == ST_LOCKED);

  // Scan rr_ptr, rr_ptr+1, ... modulo 5; the first active request wins.
  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    sum    = 4'd0;
    idx    = 3'd0;
    for (int k = 0; k < 5; k++) begin
      sum = {1'b0, rr_ptr} + 4'(k);
      idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
      if (!found && req_i[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign next_ptr = (owner == 3'd4) ? 3'd0 : owner + 3'd1;

  assign grant_o         = locked ? (5'b00001 << owner) : 5'b00000;
  assign address_route_o = locked ? owner : 3'b111;
  assign valid_o         = locked & req_i[owner];
  assign xfer_o          = valid_o & out_ready_i;
  assign release_tail    = xfer_o & tail_i[owner];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] stall_cnt;

  // Fires on the stall cycle that brings the count up to TIMEOUT_CYCLES.
  assign expire = locked & ~xfer_o &
                  (stall_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (!locked || xfer_o || expire) begin
      stall_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign timeout_o = expire;
`else
  assign expire    = 1'b0;
  assign timeout_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      owner  <= 3'd0;
      rr_ptr <= 3'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (found) begin
            state <= ST_LOCKED;
            owner <= winner;
          end
        end
        ST_LOCKED: begin
          if (release_tail || expire) begin
            state  <= ST_IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Per-output-port packet arbiter for the NoC router. One instance per output port (N/S/E/W/Local).
- Shares the port between five input requesters using round-robin selection.
- Holds each grant for a whole packet, from the winning request through its tail flit.
- Drives the 3-bit route select of that port's data mux, and qualifies flit transfers against downstream readiness.

Parameters:
- TIMEOUT_CYCLES, 255: stall cycles allowed while locked before forced release (used only with ARB_TIMEOUT_EN).
- CNT_W, 8: width of the stall counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  reset; asynchronous and active-high.
- req_i  in  5  per-requester flit-valid; bit order [0]=N, [1]=S, [2]=E, [3]=W, [4]=Local.
- tail_i  in  5  per-requester flag: the current flit is the packet tail. Sampled only for the granted requester.
- out_ready_i  in  1  downstream can accept a flit this cycle.
- grant_o  out  5  one-hot grant to the requester; all zeros when idle.
- address_route_o  out  3  mux select: 000 N, 001 S, 010 E, 011 W, 100 Local, 111 none.
- valid_o  out  1  flit presented downstream this cycle.
- xfer_o  out  1  flit transferred this cycle (valid_o and out_ready_i).
- timeout_o  out  1  one-cycle pulse on forced release. Tied 0 when ARB_TIMEOUT_EN is not defined.

Behaviour:
- Reset (async, rst_i=1): state=IDLE, rr_ptr=0, grant_o=0, address_route_o=111, valid_o=0, xfer_o=0, timeout_o=0, stall counter=0.
- State IDLE:
  - Outputs: grant_o=0, address_route_o=111, valid_o=0.
  - If any req_i bit is set, pick the winner by round-robin. Search index rr_ptr, rr_ptr+1, ... mod 5; the first set bit wins.
  - Register the winner index g and go to LOCKED on the next edge. Grant latency is 1 cycle from request.
  - If req_i=0, remain in IDLE.
- State LOCKED(g):
  - grant_o = one-hot(g); address_route_o = binary g (0..4).
  - valid_o = req_i[g]; xfer_o = valid_o and out_ready_i.
  - If req_i[g]=0 mid-packet: hold the lock, valid_o=0, no transfer.
  - Requests from other ports are ignored while locked; no preemption.
  - When xfer_o=1 and tail_i[g]=1: rr_ptr <= (g+1) mod 5, and the state returns to IDLE on that edge.
  - A single-flit packet has its head and tail in the same flit. It releases on its first transfer.
- Back-to-back packets: after a tail there is one mandatory IDLE cycle (bubble) before the next grant. This holds even if requests are pending.
- Fairness: a continuously requesting port waits at most 4 packets before it is granted.
- tail_i with xfer_o=0 has no effect.
- out_ready_i while IDLE is ignored.
- All outputs are registered state or direct combinational functions of state and inputs. There is no combinational path from req_i to grant_o.
- The encoding 101/110 is never driven.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - While LOCKED, the stall counter increments on every cycle with xfer_o=0, and clears on any transfer.
  - When the counter reaches TIMEOUT_CYCLES, the arbiter pulses timeout_o for one cycle.
  - On that same edge it forces state to IDLE and sets rr_ptr=(g+1) mod 5.
  - The counter clears on entry to IDLE and on reset.
- Not defined:
  - No counter exists; the lock is held indefinitely until the tail transfers.
  - timeout_o is constant 0.

Test Plan:
- Reset mid-packet: hold LOCKED(2) and assert rst_i asynchronously. Outputs go to grant_o=0 and address_route_o=111 immediately. The first post-reset request req_i=5'b11111 grants N (grant_o=00001).
- Single requester: req_i=00100 with tail_i[2]=1 and out_ready_i=1. grant_o=00100 and route=010 one cycle later. xfer_o=1 for one cycle, then IDLE, with rr_ptr=3.
- Round-robin: all five requesting 1-flit packets, out_ready_i=1. Grant order is N,S,E,W,L,N, with route 000,001,010,011,100,000, and one IDLE cycle between grants.
- Backpressure: a 3-flit packet from W with out_ready_i low on cycles 2–4. valid_o stays 1 and xfer_o=0 during the stall. Route stays 011, exactly 3 xfer_o pulses occur, and release follows the tail.
- Requester gap: Local drops req_i for 2 cycles mid-packet. valid_o=0 and the lock is held. An S request is not granted until the Local tail transfers.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=4: E locked with out_ready_i=0. After 4 stall cycles timeout_o pulses once and the arbiter returns to IDLE. The pending S request is then granted next only if no request with index in {3,4,0} is pending, since the search starts at rr_ptr=3.
